// File: rtl/lbm_pkg.sv
// lbm_pkg: shared requester encodings and arbiter state type for the lattice write path
package lbm_pkg;
  typedef logic [1:0] src_t;
  localparam src_t SRC_COLLIDE = 2'd0;
  localparam src_t SRC_STREAM = 2'd1;
  localparam src_t SRC_BOUND = 2'd2;
  typedef enum logic {ARB, LOCKED} arb_state_t;
endpackage

// File: rtl/lbm_df_write_arbiter_mux3.sv
// mux3: 3:1 data mux driven by a 2-bit select (select 3 falls back to input a)
module mux3 #(
  parameter int W = 8
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);
  assign y = sel == 2'd2 ? c : sel == 2'd1 ? b : a;
endmodule

// File: rtl/lbm_df_write_arbiter_rr_pick3.sv
// rr_pick3: round-robin picker over 3 requesters, searching last+1, last+2, last (mod 3); grant holds last when idle
module rr_pick3
  import lbm_pkg::*;
(
  input  logic [2:0] valid,
  input  src_t       last,
  output src_t       grant,
  output logic       any
);
  src_t n1, n2;
  logic [3:0] v;
  assign v = {1'b0, valid};
  assign n1 = last == SRC_BOUND ? SRC_COLLIDE : last + 2'd1;
  assign n2 = last == SRC_COLLIDE ? SRC_BOUND : last - 2'd1;
  assign grant = v[n1] ? n1 : v[n2] ? n2 : last;
  assign any = |valid;
endmodule

// File: rtl/lbm_df_write_arbiter.sv
// lbm_df_write_arbiter: burst-granular round-robin arbiter of 3 producers into a single-entry valid/ready output stage
module lbm_df_write_arbiter
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   in_valid,
  input  logic [2:0]                   in_last,
  input  logic signed [DATA_WIDTH-1:0] in_data0,
  input  logic signed [DATA_WIDTH-1:0] in_data1,
  input  logic signed [DATA_WIDTH-1:0] in_data2,
  input  logic [ADDR_WIDTH-1:0]        in_addr0,
  input  logic [ADDR_WIDTH-1:0]        in_addr1,
  input  logic [ADDR_WIDTH-1:0]        in_addr2,
  output logic [2:0]                   in_ready,
  output logic [1:0]                   sel,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [1:0]                   out_src,
  input  logic                         out_ready,
  output logic                         locked
);
  arb_state_t state;
  src_t last_grant, owner, pick, grant;
  logic any, load_en, accept;
  logic [3:0] v, l;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] mux_y;
  rr_pick3 u_pick (
    .valid(in_valid),
    .last (last_grant),
    .grant(pick),
    .any  (any)
  );
  mux3 #(.W(DATA_WIDTH + ADDR_WIDTH)) u_mux (
    .sel(sel),
    .a  ({in_data0, in_addr0}),
    .b  ({in_data1, in_addr1}),
    .c  ({in_data2, in_addr2}),
    .y  (mux_y)
  );
  assign v = {1'b0, in_valid};
  assign l = {1'b0, in_last};
  assign grant = state == LOCKED ? owner : any ? pick : last_grant;
  assign sel = grant;
  assign load_en = !out_valid || out_ready;
  assign accept = load_en && v[grant];
  assign in_ready = accept ? 3'b001 << grant : 3'b000;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      last_grant <= SRC_BOUND;
      owner <= SRC_COLLIDE;
      locked <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
      out_src <= SRC_COLLIDE;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        {out_data, out_addr} <= mux_y;
        out_src <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && l[grant]) begin
        last_grant <= grant;
        state <= ARB;
        locked <= 1'b0;
      end else if (accept && state == ARB) begin
        owner <= grant;
        state <= LOCKED;
        locked <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lbm_df_write_arbiter.sv
// tb_lbm_df_write_arbiter: scenario tasks with inline checks plus a scoreboard monitor on the output handshake
module tb_lbm_df_write_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] in_valid, in_last, in_ready;
  logic signed [63:0] in_data0, in_data1, in_data2, out_data;
  logic [11:0] in_addr0, in_addr1, in_addr2, out_addr;
  logic [1:0] sel, out_src;
  logic out_valid, out_ready, locked;
  typedef struct {
    logic [1:0] src;
    logic [63:0] data;
    logic [11:0] addr;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  longint beat = 0;

  lbm_df_write_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
    .in_addr0(in_addr0), .in_addr1(in_addr1), .in_addr2(in_addr2),
    .in_ready(in_ready), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr), .out_src(out_src), .out_ready(out_ready), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow got src=%0d data=%0d with nothing expected", out_src, out_data);
      end else begin
        e = sb.pop_front();
        if (out_src !== e.src || out_data !== e.data || out_addr !== e.addr) begin
          bad++;
          $display("FAIL sb_beat got src=%0d data=%0d addr=%0d want src=%0d data=%0d addr=%0d",
                   out_src, out_data, out_addr, e.src, $signed(e.data), e.addr);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic r);
    in_valid = v;
    in_last = l;
    out_ready = r;
  endtask

  task automatic set_data();
    beat++;
    in_data0 = -beat;
    in_data1 = -64'sd1000 - beat;
    in_data2 = 64'sh7fff_0000_0000_0000 - beat;
    in_addr0 = 12'(beat);
    in_addr1 = 12'(beat + 1000);
    in_addr2 = 12'(beat + 2000);
  endtask

  task automatic push(input int s);
    exp_t e;
    e.src = 2'(s);
    e.data = s == 0 ? in_data0 : s == 1 ? in_data1 : in_data2;
    e.addr = s == 0 ? in_addr0 : s == 1 ? in_addr1 : in_addr2;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    drive(3'b000, 3'b000, 1'b1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 1'b1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 1'b1);
    set_data();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 64'sd0 || out_addr !== 12'd0 || out_src !== 2'd0 || locked !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got v=%b d=%0d a=%0d s=%0d lk=%b want all zero", out_valid, out_data, out_addr, out_src, locked);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (sel !== 2'd2 || in_ready !== 3'b000) begin
      bad++;
      $display("FAIL reset_sel got sel=%0d rdy=%b want sel=2 rdy=000", sel, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    drive(3'b001, 3'b001, 1'b1);
    in_data0 = -64'sd5;
    in_addr0 = 12'h123;
    @(negedge clk);
    total++;
    if (in_ready !== 3'b001 || sel !== 2'd0) begin
      bad++;
      $display("FAIL single_ready got rdy=%b sel=%0d want rdy=001 sel=0", in_ready, sel);
    end
    push(0);
    @(posedge clk);
    #1;
    drive(3'b000, 3'b000, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== -64'sd5 || out_src !== 2'd0) begin
      bad++;
      $display("FAIL single_out got v=%b d=%0d s=%0d want v=1 d=-5 s=0", out_valid, out_data, out_src);
    end
    idle(2);
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      set_data();
      drive(3'b111, 3'b111, 1'b1);
      @(negedge clk);
      total++;
      if (sel !== 2'(k % 3) || in_ready !== 3'(1 << (k % 3))) begin
        bad++;
        $display("FAIL rr_%0d got sel=%0d rdy=%b want sel=%0d", k, sel, in_ready, k % 3);
      end
      push(k % 3);
      @(posedge clk);
      #1;
    end
    idle(2);
  endtask

  task automatic test_burst();
    logic [2:0] vv[6] = '{3'b010, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101};
    logic [2:0] ll[6] = '{3'b000, 3'b101, 3'b101, 3'b111, 3'b101, 3'b101};
    int gg[6] = '{1, 1, 1, 1, 2, 0};
    logic lk[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      set_data();
      drive(vv[k], ll[k], 1'b1);
      @(negedge clk);
      total++;
      if (sel !== 2'(gg[k]) || in_ready !== 3'(1 << gg[k]) || locked !== lk[k]) begin
        bad++;
        $display("FAIL burst_%0d got sel=%0d rdy=%b lk=%b want sel=%0d lk=%b", k, sel, in_ready, locked, gg[k], lk[k]);
      end
      push(gg[k]);
      @(posedge clk);
      #1;
    end
    idle(2);
  endtask

  task automatic test_bubble();
    logic [2:0] vv[5] = '{3'b100, 3'b001, 3'b001, 3'b101, 3'b001};
    logic [2:0] ll[5] = '{3'b000, 3'b001, 3'b001, 3'b101, 3'b001};
    logic [2:0] rr[5] = '{3'b100, 3'b000, 3'b000, 3'b100, 3'b001};
    logic [1:0] ss[5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    logic lk[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      set_data();
      drive(vv[k], ll[k], 1'b1);
      @(negedge clk);
      total++;
      if (sel !== ss[k] || in_ready !== rr[k] || locked !== lk[k]) begin
        bad++;
        $display("FAIL bubble_%0d got sel=%0d rdy=%b lk=%b want sel=%0d rdy=%b lk=%b", k, sel, in_ready, locked, ss[k], rr[k], lk[k]);
      end
      if (rr[k] != 3'b000) push(int'(ss[k]));
      @(posedge clk);
      #1;
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    logic signed [63:0] held;
    logic signed [63:0] next_d;
    apply_reset();
    set_data();
    drive(3'b001, 3'b001, 1'b1);
    held = in_data0;
    @(negedge clk);
    push(0);
    @(posedge clk);
    #1;
    set_data();
    next_d = in_data1;
    drive(3'b010, 3'b010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 3'b000 || out_valid !== 1'b1 || out_data !== held || sel !== 2'd1) begin
        bad++;
        $display("FAIL bp_hold_%0d got rdy=%b v=%b d=%0d sel=%0d want rdy=000 v=1 d=%0d sel=1", k, in_ready, out_valid, out_data, sel, held);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 3'b010) begin
      bad++;
      $display("FAIL bp_release got rdy=%b want 010", in_ready);
    end
    push(1);
    @(posedge clk);
    #1;
    drive(3'b000, 3'b000, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== next_d || out_src !== 2'd1) begin
      bad++;
      $display("FAIL bp_noBubble got v=%b d=%0d s=%0d want v=1 d=%0d s=1", out_valid, out_data, out_src, next_d);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain got v=%b want 0", out_valid);
    end
    idle(1);
  endtask

  task automatic test_reset_locked();
    apply_reset();
    set_data();
    drive(3'b010, 3'b000, 1'b1);
    @(negedge clk);
    push(1);
    @(posedge clk);
    #1;
    drive(3'b010, 3'b000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || locked !== 1'b0) begin
      bad++;
      $display("FAIL rst_async got v=%b lk=%b want 0 0", out_valid, locked);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_data();
    drive(3'b111, 3'b111, 1'b1);
    @(negedge clk);
    total++;
    if (sel !== 2'd0 || in_ready !== 3'b001) begin
      bad++;
      $display("FAIL rst_restart got sel=%0d rdy=%b want sel=0 rdy=001", sel, in_ready);
    end
    push(0);
    @(posedge clk);
    #1;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_bubble();
    test_backpressure();
    test_reset_locked();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
